regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between two write-back requesters:
//  req0 (ALU/writeback path) and req1 (multi-cycle unit / load return).
//  - Round-robin arbitration with a valid/ready handshake.
//  - Registered write command (RegWrite, WriteRegister, WriteData) that drives the write decoder.
//  - Pending-write scoreboard with rs/rt hazard lookup for the issue stage.

---
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two write-back
// requesters, with a registered write command and a pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  claim_valid,
  input  logic [ADDR_WIDTH-1:0] claim_reg,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [NUM_REGS-1:0]   busy_mask,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy
);

  typedef enum logic {GRANT0 = 1'b0, GRANT1 = 1'b1} grantState_t;

  grantState_t           lastGrant;
  logic                  grant0;
  logic                  grant1;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] xferReg;
  logic [DATA_WIDTH-1:0] xferData;
  logic [NUM_REGS-1:0]   busyNext;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    grant0   = req0_valid & (~req1_valid | (lastGrant == GRANT1));
    grant1   = req1_valid & (~req0_valid | (lastGrant == GRANT0));
    transfer = grant0 | grant1;
    xferReg  = grant0 ? req0_reg  : req1_reg;
    xferData = grant0 ? req0_data : req1_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Clears are applied before the claim so a new producer overrides a completing one.
  always_comb begin
    busyNext = busy_mask;
    if (grant0) busyNext[req0_reg] = 1'b0;
    if (grant1) busyNext[req1_reg] = 1'b0;
    if (claim_valid && (claim_reg != '0)) busyNext[claim_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      busy_mask     <= '0;
      lastGrant     <= GRANT1;
    end else begin
      busy_mask <= busyNext;
      RegWrite  <= transfer && (xferReg != '0);
      if (transfer) begin
        WriteRegister <= xferReg;
        WriteData     <= xferData;
        lastGrant     <= grant0 ? GRANT0 : GRANT1;
      end
    end
  end

  assign rs_busy = (rs_addr != '0) && busy_mask[rs_addr];
  assign rt_busy = (rt_addr != '0) && busy_mask[rt_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: arbitration order,
// write command latency, register-0 suppression, scoreboard and async reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        claim_valid;
  logic [4:0]  claim_reg;
  logic        req0_valid;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] busy_mask;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;

  int vectorsApplied = 0;
  int miscompares    = 0;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .claim_valid(claim_valid), .claim_reg(claim_reg),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .busy_mask(busy_mask), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs change and registers are sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    claim_valid = 1'b0; claim_reg = '0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    rs_addr = '0; rt_addr = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rstRegWrite", 64'(RegWrite), 64'd0);
    checkOutput("rstWriteReg", 64'(WriteRegister), 64'd0);
    checkOutput("rstWriteData", 64'(WriteData), 64'd0);
    checkOutput("rstBusy", 64'(busy_mask), 64'd0);
    reset = 1'b0;

    // Single requester 0 write to r5.
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checkOutput("t1Ready0", 64'(req0_ready), 64'd1);
    checkOutput("t1Ready1", 64'(req1_ready), 64'd0);
    applyStimulus();
    req0_valid = 1'b0;
    checkOutput("t1RegWrite", 64'(RegWrite), 64'd1);
    checkOutput("t1WriteReg", 64'(WriteRegister), 64'd5);
    checkOutput("t1WriteData", 64'(WriteData), 64'hDEADBEEF);
    applyStimulus();
    checkOutput("t1IdleRegWrite", 64'(RegWrite), 64'd0);
    checkOutput("t1IdleHoldReg", 64'(WriteRegister), 64'd5);
    checkOutput("t1IdleHoldData", 64'(WriteData), 64'hDEADBEEF);

    // Requester 1 writes r0: accepted but dropped; claim of r0 is ignored.
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'h1234;
    #1;
    checkOutput("r0Ready1", 64'(req1_ready), 64'd1);
    applyStimulus();
    req1_valid = 1'b0;
    checkOutput("r0RegWrite", 64'(RegWrite), 64'd0);
    checkOutput("r0WriteData", 64'(WriteData), 64'h1234);
    claim_valid = 1'b1; claim_reg = 5'd0;
    applyStimulus();
    claim_valid = 1'b0;
    checkOutput("r0ClaimBusy", 64'(busy_mask), 64'd0);
    rs_addr = 5'd0;
    #1;
    checkOutput("r0RsBusy", 64'(rs_busy), 64'd0);

    // Contention: last grant was requester 1, so grants run 0,1,0,1.
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'hA3A3A3A3;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'hB4B4B4B4;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("rrReady0_%0d", k), 64'(req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rrReady1_%0d", k), 64'(req1_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
      applyStimulus();
      checkOutput($sformatf("rrRegWrite_%0d", k), 64'(RegWrite), 64'd1);
      checkOutput($sformatf("rrWriteReg_%0d", k), 64'(WriteRegister), (k % 2 == 0) ? 64'd3 : 64'd4);
      checkOutput($sformatf("rrWriteData_%0d", k), 64'(WriteData),
                  (k % 2 == 0) ? 64'hA3A3A3A3 : 64'hB4B4B4B4);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Claim r7, then requester 1 completes it.
    claim_valid = 1'b1; claim_reg = 5'd7;
    applyStimulus();
    claim_valid = 1'b0; rt_addr = 5'd7;
    #1;
    checkOutput("sbBusy7", 64'(busy_mask), 64'h80);
    checkOutput("sbRtBusy", 64'(rt_busy), 64'd1);
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h77;
    #1;
    checkOutput("sbRtBusyPending", 64'(rt_busy), 64'd1);
    checkOutput("sbReady1", 64'(req1_ready), 64'd1);
    applyStimulus();
    req1_valid = 1'b0;
    checkOutput("sbBusyCleared", 64'(busy_mask), 64'd0);
    checkOutput("sbRtBusyCleared", 64'(rt_busy), 64'd0);
    checkOutput("sbRegWrite", 64'(RegWrite), 64'd1);
    checkOutput("sbWriteReg", 64'(WriteRegister), 64'd7);

    // Same-cycle claim and completion of r9: set wins.
    claim_valid = 1'b1; claim_reg = 5'd9;
    applyStimulus();
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h99;
    applyStimulus();
    claim_valid = 1'b0;
    rs_addr = 5'd9;
    #1;
    checkOutput("setWinsBusy", 64'(busy_mask), 64'h200);
    checkOutput("setWinsRsBusy", 64'(rs_busy), 64'd1);
    checkOutput("setWinsRegWrite", 64'(RegWrite), 64'd1);
    applyStimulus();
    req0_valid = 1'b0;
    checkOutput("r9Cleared", 64'(busy_mask), 64'd0);
    checkOutput("r9RsBusy", 64'(rs_busy), 64'd0);

    // Async reset with a transfer pending.
    claim_valid = 1'b1; claim_reg = 5'd12;
    applyStimulus();
    claim_valid = 1'b0;
    checkOutput("preRstBusy", 64'(busy_mask), 64'h1000);
    req0_valid = 1'b1; req0_reg = 5'd6; req0_data = 32'h66;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstRegWrite", 64'(RegWrite), 64'd0);
    checkOutput("midRstWriteReg", 64'(WriteRegister), 64'd0);
    checkOutput("midRstWriteData", 64'(WriteData), 64'd0);
    checkOutput("midRstBusy", 64'(busy_mask), 64'd0);
    req0_valid = 1'b0;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("postRstRegWrite", 64'(RegWrite), 64'd0);
    checkOutput("postRstWriteReg", 64'(WriteRegister), 64'd0);

    // After reset requester 0 wins the first contention.
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h22;
    #1;
    checkOutput("postRstReady0", 64'(req0_ready), 64'd1);
    checkOutput("postRstReady1", 64'(req1_ready), 64'd0);
    applyStimulus();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("postRstWriteData", 64'(WriteData), 64'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
